// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - WIDTH-bit adder sequenced through one 4-bit slice, LSB nibble first
// Valid/ready on both sides; one operand set in flight, result held until consumed.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic             in_ready_q, out_valid_q, out_cout_q, busy_q;
  logic [WIDTH-1:0] out_sum_q;

  logic [IW+1:0]    shamt;
  logic [3:0]       nib_a, nib_b;
  logic [4:0]       nib_sum;
  logic             last_step;

  // The single shared slice: select the current nibble and splice its sum back in place.
  always_comb begin
    shamt     = {idx_q, 2'b00};
    nib_a     = 4'(a_q >> shamt);
    nib_b     = 4'(b_q >> shamt);
    nib_sum   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
    sum_d     = (sum_q & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(nib_sum[3:0]) << shamt);
    last_step = (idx_q == IW'(NIB - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            carry_q    <= in_cin;
            idx_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= nib_sum[4];
          if (last_step) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= sum_d;
            out_cout_q  <= nib_sum[4];
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          // Result is only visible while valid; cleared on handshake.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign busy      = busy_q;

endmodule
